// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the carry-save resolver.
package csa_pkg;

  localparam int unsigned W_DEF     = 18;
  localparam int unsigned CHUNK_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Cycles needed to resolve the W+1-bit operands CHUNK bits at a time.
  function automatic int unsigned calc_nchunk(input int unsigned w, input int unsigned chunk);
    return (w + 1 + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/csa_resolver_if.sv
// Handshake bus of the resolver: input pair on one side, binary result on the other.
interface csa_resolver_if #(
  parameter int unsigned W = 18
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] cout;
  logic [W-1:0] sum;
  logic         out_valid;
  logic         out_ready;
  logic [W+1:0] result;
  logic         ha_err;

  modport master (
    output in_valid, cout, sum, out_ready,
    input  in_ready, out_valid, result, ha_err
  );

  modport slave (
    input  in_valid, cout, sum, out_ready,
    output in_ready, out_valid, result, ha_err
  );
endinterface

// File: rtl/csa_chunk_adder.sv
// CHUNK-bit ripple adder built from a chain of full-adder cells.

// Single-bit full adder cell.
module csa_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum_c,
  output logic o_cout_c
);
  assign o_sum_c  = i_a ^ i_b ^ i_cin;
  assign o_cout_c = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module csa_chunk_adder #(
  parameter int unsigned CHUNK = 6
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum_c,
  output logic             o_cout_c
);
  logic [CHUNK:0] w_carry;

  assign w_carry[0] = i_cin;
  assign o_cout_c   = w_carry[CHUNK];

  // Ripple chain, LSB first.
  for (genvar g = 0; g < CHUNK; g++) begin : g_fa
    csa_full_adder u_fa (
      .i_a      (i_a[g]),
      .i_b      (i_b[g]),
      .i_cin    (w_carry[g]),
      .o_sum_c  (o_sum_c[g]),
      .o_cout_c (w_carry[g+1])
    );
  end
endmodule

// File: rtl/csa_resolver.sv
// Iterative resolver: turns a (cout, sum) carry-save pair into sum + 2*cout,
// CHUNK bits per cycle through one small ripple adder.
// Optional build macro: CSA_RESOLVER_HA_CHECK_EN (flags pairs that a
// half-adder row could not have produced).
module csa_resolver
  import csa_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned CHUNK = CHUNK_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  csa_resolver_if.slave  bus
);

  localparam int unsigned NCHUNK = calc_nchunk(W, CHUNK);
  localparam int unsigned PADW   = NCHUNK * CHUNK;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned RW     = W + 2;

  state_e          r_state;
  state_e          w_state_nxt;
  logic            w_accept;
  logic            w_last;

  logic [PADW-1:0] r_x;
  logic [PADW-1:0] r_y;
  logic [PADW:0]   r_acc;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic            r_in_ready;
  logic            r_out_valid;

  logic [CHUNK-1:0] w_chunk_sum;
  logic             w_chunk_cout;
  logic             w_unused_acc;

  // Low chunk of the shifting operands plus the stored carry.
  csa_chunk_adder #(.CHUNK(CHUNK)) u_adder (
    .i_a      (r_x[CHUNK-1:0]),
    .i_b      (r_y[CHUNK-1:0]),
    .i_cin    (r_carry),
    .o_sum_c  (w_chunk_sum),
    .o_cout_c (w_chunk_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and accept decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = (r_idx == IW'(NCHUNK - 1));
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch, chunk-wise accumulation and handshake flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_x         <= '0;
      r_y         <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_x     <= PADW'({1'b0, bus.sum});
        r_y     <= PADW'({bus.cout, 1'b0});
        r_acc   <= '0;
        r_idx   <= '0;
        r_carry <= 1'b0;
      end else if (r_state == BUSY) begin
        r_x     <= r_x >> CHUNK;
        r_y     <= r_y >> CHUNK;
        r_carry <= w_chunk_cout;
        r_idx   <= r_idx + IW'(1);
        for (int k = 0; k < int'(NCHUNK); k++) begin
          if (r_idx == IW'(k)) r_acc[k*CHUNK +: CHUNK] <= w_chunk_sum;
        end
        if (w_last) r_acc[PADW] <= w_chunk_cout;
      end
    end
  end

  // Padding bits above the result only ever hold zero.
  assign w_unused_acc = ^r_acc;

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_acc[RW-1:0];

`ifdef CSA_RESOLVER_HA_CHECK_EN
  logic r_ha_pend;

  // A half-adder row never sets sum and carry at the same position.
  always_ff @(posedge clk) begin
    if (!reset_n)      r_ha_pend <= 1'b0;
    else if (w_accept) r_ha_pend <= |(bus.sum & bus.cout);
  end

  assign bus.ha_err = r_out_valid & r_ha_pend;
`else
  assign bus.ha_err = 1'b0;
`endif

endmodule

// File: tb/tb_csa_resolver.sv
// Directed plus randomized bench for csa_resolver at several CHUNK widths.
module tb_csa_resolver;

  localparam int unsigned W = 18;
  localparam logic [W-1:0] MASK = {W{1'b1}};
`ifdef CSA_RESOLVER_HA_CHECK_EN
  localparam bit HA_ON = 1'b1;
`else
  localparam bit HA_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  csa_resolver_if #(.W(W)) bus  ();
  csa_resolver_if #(.W(W)) sw1  ();
  csa_resolver_if #(.W(W)) sw7  ();
  csa_resolver_if #(.W(W)) sw19 ();

  csa_resolver #(.W(W), .CHUNK(6))  dut    (.clk(clk), .reset_n(reset_n), .bus(bus));
  csa_resolver #(.W(W), .CHUNK(1))  dut_c1 (.clk(clk), .reset_n(reset_n), .bus(sw1));
  csa_resolver #(.W(W), .CHUNK(7))  dut_c7 (.clk(clk), .reset_n(reset_n), .bus(sw7));
  csa_resolver #(.W(W), .CHUNK(19)) dut_c19(.clk(clk), .reset_n(reset_n), .bus(sw19));

  // Reference: the plain value of the redundant pair.
  function automatic logic [W+1:0] model(input logic [W-1:0] s, input logic [W-1:0] c);
    return (W+2)'(s) + ((W+2)'(c) * 2);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the default-CHUNK instance with out_ready high.
  task automatic op(input logic [W-1:0] s, input logic [W-1:0] c, input string tag, input bit want_ha);
    int n;
    int lat;
    bus.sum = s; bus.cout = c; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin tick(); n++; end
    chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0; bus.sum = ~s; bus.cout = ~c;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin tick(); lat++; end
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_res"}, 64'(bus.result), 64'(model(s, c)));
    chk({tag, "_ha"},  64'(bus.ha_err), 64'(want_ha));
    tick();
    chk({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [W+1:0] expq[$];
    logic [W-1:0] a, b, s, c;
    logic [W+1:0] r1, r7, r19, want;
    int cyc, last, nacc, nres, n, l1, l7, l19;
    bit acc, rel;

    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.sum = '0; bus.cout = '0; bus.out_ready = 1'b1;
    sw1.in_valid = 1'b0;  sw1.sum = '0;  sw1.cout = '0;  sw1.out_ready = 1'b1;
    sw7.in_valid = 1'b0;  sw7.sum = '0;  sw7.cout = '0;  sw7.out_ready = 1'b1;
    sw19.in_valid = 1'b0; sw19.sum = '0; sw19.cout = '0; sw19.out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid",  64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.result),    64'd0);
    chk("rst_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_ha",     64'(bus.ha_err),    64'd0);
    reset_n = 1'b1;
    tick();

    // Basic: latency and in_ready shape.
    bus.sum = 18'h00001; bus.cout = 18'h00001; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("basic_rdy%0d", k), 64'(bus.in_ready),  64'd0);
      chk($sformatf("basic_ov%0d", k),  64'(bus.out_valid), 64'(k == 4));
      if (k == 4) chk("basic_res", 64'(bus.result), 64'h00003);
      tick();
    end
    chk("basic_idle_rdy", 64'(bus.in_ready),  64'd1);
    chk("basic_idle_ov",  64'(bus.out_valid), 64'd0);

    // Extremes.
    op(18'h3FFFF, 18'h00000, "ext_sum", 1'b0);
    chk("ext_sum_const", 64'(model(18'h3FFFF, 18'h0)), 64'h3FFFF);
    op(18'h00000, 18'h3FFFF, "ext_cout", 1'b0);
    op(18'h3FFFF, 18'h3FFFF, "ext_both", HA_ON);

    // Backpressure: DONE held for 10 cycles.
    bus.out_ready = 1'b0; bus.sum = 18'h12345; bus.cout = 18'h0F0F0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin tick(); n++; end
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp_ov%0d", k),  64'(bus.out_valid), 64'd1);
      chk($sformatf("bp_res%0d", k), 64'(bus.result),    64'(model(18'h12345, 18'h0F0F0)));
      chk($sformatf("bp_rdy%0d", k), 64'(bus.in_ready),  64'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_ov",  64'(bus.out_valid), 64'd0);
    chk("bp_release_rdy", 64'(bus.in_ready),  64'd1);

    // Reset during the second BUSY cycle.
    bus.sum = 18'h2AAAA; bus.cout = 18'h15555; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    chk("mid_rst_ov",  64'(bus.out_valid), 64'd0);
    chk("mid_rst_res", 64'(bus.result),    64'd0);
    chk("mid_rst_rdy", 64'(bus.in_ready),  64'd1);
    reset_n = 1'b1;
    op(18'h00010, 18'h00008, "post_rst", 1'b0);

    // Back-to-back half-adder pairs with in_valid held high.
    bus.out_ready = 1'b1;
    a = 18'($urandom) & MASK; b = 18'($urandom) & MASK;
    bus.sum = a ^ b; bus.cout = a & b; bus.in_valid = 1'b1;
    cyc = 0; last = 0; nacc = 0; nres = 0;
    while (nres < 100 && cyc < 1000) begin
      acc = bus.in_ready && bus.in_valid;
      rel = bus.out_valid && bus.out_ready;
      if (rel) begin
        chk("b2b_q", 64'(expq.size() != 0), 64'd1);
        want = (expq.size() != 0) ? expq.pop_front() : '0;
        chk($sformatf("b2b_res%0d", nres), 64'(bus.result), 64'(want));
        chk($sformatf("b2b_ha%0d", nres),  64'(bus.ha_err), 64'd0);
        nres++;
      end
      if (acc) begin
        expq.push_back((W+2)'(a) + (W+2)'(b));
        if (nacc > 0) chk($sformatf("b2b_gap%0d", nacc), 64'(cyc - last), 64'd6);
        last = cyc;
        nacc++;
      end
      tick();
      cyc++;
      if (acc) begin
        if (nacc < 100) begin
          a = 18'($urandom) & MASK; b = 18'($urandom) & MASK;
          bus.sum = a ^ b; bus.cout = a & b;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    chk("b2b_count", 64'(nres), 64'd100);

    // CHUNK sweep on the three extra instances.
    for (int t = 0; t < 5; t++) begin
      s = 18'($urandom) & MASK; c = 18'($urandom) & MASK;
      sw1.sum = s;  sw1.cout = c;  sw1.in_valid = 1'b1;
      sw7.sum = s;  sw7.cout = c;  sw7.in_valid = 1'b1;
      sw19.sum = s; sw19.cout = c; sw19.in_valid = 1'b1;
      tick();
      sw1.in_valid = 1'b0; sw7.in_valid = 1'b0; sw19.in_valid = 1'b0;
      sw1.sum = ~s; sw7.cout = ~c; sw19.sum = ~s;
      l1 = -1; l7 = -1; l19 = -1; r1 = '0; r7 = '0; r19 = '0;
      for (int k = 1; k <= 30; k++) begin
        tick();
        if (sw1.out_valid && l1 < 0)  begin l1 = k;  r1 = sw1.result;  end
        if (sw7.out_valid && l7 < 0)  begin l7 = k;  r7 = sw7.result;  end
        if (sw19.out_valid && l19 < 0) begin l19 = k; r19 = sw19.result; end
      end
      chk($sformatf("c1_lat%0d", t),  64'(l1),  64'd19);
      chk($sformatf("c7_lat%0d", t),  64'(l7),  64'd3);
      chk($sformatf("c19_lat%0d", t), 64'(l19), 64'd1);
      chk($sformatf("c1_res%0d", t),  64'(r1),  64'(model(s, c)));
      chk($sformatf("c7_res%0d", t),  64'(r7),  64'(model(s, c)));
      chk($sformatf("c19_res%0d", t), 64'(r19), 64'(model(s, c)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
